// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_DW_DEF = 34;
  localparam int unsigned FIFO_AW_DEF = 2;

  // Occupancy quartile encodings reported on the level output.
  typedef enum logic [1:0] {
    LVL_Q0 = 2'b00,
    LVL_Q1 = 2'b01,
    LVL_Q2 = 2'b10,
    LVL_Q3 = 2'b11
  } level_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/fifo_mem_sc.sv
// Single-clock storage array: one write port, one read port that is either
// registered with an enable (SYNC_RD=1) or purely combinational (SYNC_RD=0).
module fifo_mem_sc #(
  parameter int unsigned DW      = 34,
  parameter int unsigned AW      = 2,
  parameter int unsigned SYNC_RD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Array write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (SYNC_RD != 0) begin : g_sync_rd
    // Registered read port, zeroed by reset or clear, held when not reading.
    always_ff @(posedge clk) begin
      if (!rst || clr) rdata <= '0;
      else if (re)     rdata <= mem[raddr];
    end
  end else begin : g_async_rd
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, rst, clr, re};
    assign rdata       = mem[raddr];
  end

endmodule

// File: rtl/generic_fifo_sc_p.sv
// Parametrised single-clock FIFO with exact occupancy, registered status,
// sticky overflow/underflow and optional first-word-fall-through reads.
module generic_fifo_sc_p
  import fifo_pkg::*;
#(
  parameter int unsigned DW        = FIFO_DW_DEF,
  parameter int unsigned AW        = FIFO_AW_DEF,
  parameter int unsigned AF_THRESH = (1 << AW) - 1,
  parameter int unsigned AE_THRESH = 1,
  parameter int unsigned FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic [1:0]    level,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = clog2(DEPTH + 1);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr_ok;
  logic          rd_ok;
  logic          mem_we;
  logic          mem_re;
  logic [CW-1:0] count_next;
  logic          full_next;
  logic          empty_next;
  logic          af_next;
  logic          ae_next;
  logic [1:0]    level_next;

  // Accept decisions and next-state status, all derived from count_next.
  always_comb begin
    wr_ok      = we & ~full;
    rd_ok      = re & ~empty;
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    full_next  = (count_next == CW'(DEPTH));
    empty_next = (count_next == CW'(0));
    af_next    = (count_next >= CW'(AF_THRESH));
    ae_next    = (count_next <= CW'(AE_THRESH));
    if (count_next == CW'(DEPTH)) level_next = LVL_Q3;
    else                          level_next = count_next[AW-1:AW-2];
  end

  // Keep the array quiet on edges where the control state is being reset.
  assign mem_we = wr_ok & rst & ~clr;
  assign mem_re = rd_ok & rst & ~clr;

  // Pointers, occupancy, status flags and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      level        <= LVL_Q0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      count        <= count_next;
      full         <= full_next;
      empty        <= empty_next;
      almost_full  <= af_next;
      almost_empty <= ae_next;
      level        <= level_next;
      overflow     <= overflow  | (we & full);
      underflow    <= underflow | (re & empty);
    end
  end

  fifo_mem_sc #(
    .DW      (DW),
    .AW      (AW),
    .SYNC_RD ((FWFT != 0) ? 0 : 1)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .we    (mem_we),
    .waddr (wp),
    .wdata (din),
    .re    (mem_re),
    .raddr (rp),
    .rdata (dout)
  );

endmodule

// File: tb/tb_generic_fifo_sc_p.sv
// Directed bench: a standard-mode instance driven from a vector table plus
// hand-written sequences, and a FWFT instance exercised separately.
module tb_generic_fifo_sc_p;

  logic clk;
  logic rst;

  logic        s_clr, s_we, s_re;
  logic [33:0] s_din, s_dout;
  logic        s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic [2:0]  s_count;
  logic [1:0]  s_level;

  logic        f_clr, f_we, f_re;
  logic [33:0] f_din, f_dout;
  logic        f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [2:0]  f_count;
  logic [1:0]  f_level;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        we;
    logic        re;
    logic        clr;
    logic [33:0] din;
    logic [2:0]  cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ov;
    logic        un;
    logic [1:0]  lvl;
    logic        chk_d;
    logic [33:0] dout;
  } vec_t;

  vec_t vq[$];

  generic_fifo_sc_p #(.DW(34), .AW(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) dut_s (
    .clk(clk), .rst(rst), .clr(s_clr), .din(s_din), .we(s_we), .re(s_re),
    .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .level(s_level),
    .overflow(s_ov), .underflow(s_un)
  );

  generic_fifo_sc_p #(.DW(34), .AW(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .clr(f_clr), .din(f_din), .we(f_we), .re(f_re),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .level(f_level),
    .overflow(f_ov), .underflow(f_un)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic c, input logic [33:0] d,
                     input logic [2:0] cnt, input logic f, input logic e,
                     input logic af, input logic ae, input logic ov, input logic un,
                     input logic [1:0] lv, input logic cd, input logic [33:0] dv);
    vec_t v;
    v.we = w; v.re = r; v.clr = c; v.din = d;
    v.cnt = cnt; v.full = f; v.empty = e; v.af = af; v.ae = ae;
    v.ov = ov; v.un = un; v.lvl = lv; v.chk_d = cd; v.dout = dv;
    vq.push_back(v);
  endtask

  task automatic chk_std(input int idx, input vec_t v);
    chk("count", idx, 64'(s_count), 64'(v.cnt));
    chk("full", idx, 64'(s_full), 64'(v.full));
    chk("empty", idx, 64'(s_empty), 64'(v.empty));
    chk("almost_full", idx, 64'(s_af), 64'(v.af));
    chk("almost_empty", idx, 64'(s_ae), 64'(v.ae));
    chk("overflow", idx, 64'(s_ov), 64'(v.ov));
    chk("underflow", idx, 64'(s_un), 64'(v.un));
    chk("level", idx, 64'(s_level), 64'(v.lvl));
    if (v.chk_d) chk("dout", idx, 64'(s_dout), 64'(v.dout));
  endtask

  initial begin
    vec_t rv;
    clk = 1'b0; rst = 1'b0;
    n_cmp = 0; n_fail = 0;
    s_clr = 0; s_we = 0; s_re = 0; s_din = '0;
    f_clr = 0; f_we = 0; f_re = 0; f_din = '0;

    // we re clr din | cnt full empty af ae ov un lvl | chk_d dout
    add(1, 0, 0, 34'h1,  3'd1, 0, 0, 0, 1, 0, 0, 2'd1, 0, 34'h0);
    add(1, 0, 0, 34'h2,  3'd2, 0, 0, 0, 0, 0, 0, 2'd2, 0, 34'h0);
    add(1, 0, 0, 34'h3,  3'd3, 0, 0, 1, 0, 0, 0, 2'd3, 0, 34'h0);
    add(1, 0, 0, 34'h4,  3'd4, 1, 0, 1, 0, 0, 0, 2'd3, 0, 34'h0);
    add(1, 0, 0, 34'h5,  3'd4, 1, 0, 1, 0, 1, 0, 2'd3, 0, 34'h0);
    add(0, 1, 0, 34'h0,  3'd3, 0, 0, 1, 0, 1, 0, 2'd3, 1, 34'h1);
    add(0, 1, 0, 34'h0,  3'd2, 0, 0, 0, 0, 1, 0, 2'd2, 1, 34'h2);
    add(0, 1, 0, 34'h0,  3'd1, 0, 0, 0, 1, 1, 0, 2'd1, 1, 34'h3);
    add(0, 1, 0, 34'h0,  3'd0, 0, 1, 0, 1, 1, 0, 2'd0, 1, 34'h4);
    add(0, 1, 0, 34'h0,  3'd0, 0, 1, 0, 1, 1, 1, 2'd0, 1, 34'h4);
    add(0, 0, 1, 34'h0,  3'd0, 0, 1, 0, 1, 0, 0, 2'd0, 1, 34'h0);
    add(1, 0, 0, 34'h10, 3'd1, 0, 0, 0, 1, 0, 0, 2'd1, 1, 34'h0);
    add(1, 0, 0, 34'h11, 3'd2, 0, 0, 0, 0, 0, 0, 2'd2, 1, 34'h0);
    for (int k = 0; k < 10; k++)
      add(1, 1, 0, 34'(32'h12 + k), 3'd2, 0, 0, 0, 0, 0, 0, 2'd2, 1, 34'(32'h10 + k));
    add(0, 1, 0, 34'h0,  3'd1, 0, 0, 0, 1, 0, 0, 2'd1, 1, 34'h1A);
    add(0, 1, 0, 34'h0,  3'd0, 0, 1, 0, 1, 0, 0, 2'd0, 1, 34'h1B);
    add(1, 1, 0, 34'h20, 3'd1, 0, 0, 0, 1, 0, 1, 2'd1, 1, 34'h1B);
    add(1, 0, 0, 34'h21, 3'd2, 0, 0, 0, 0, 0, 1, 2'd2, 1, 34'h1B);
    add(1, 0, 0, 34'h22, 3'd3, 0, 0, 1, 0, 0, 1, 2'd3, 1, 34'h1B);
    add(1, 0, 0, 34'h23, 3'd4, 1, 0, 1, 0, 0, 1, 2'd3, 1, 34'h1B);
    add(1, 1, 0, 34'h24, 3'd3, 0, 0, 1, 0, 1, 1, 2'd3, 1, 34'h20);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rv.cnt = 0; rv.full = 0; rv.empty = 1; rv.af = 0; rv.ae = 1;
    rv.ov = 0; rv.un = 0; rv.lvl = 0; rv.chk_d = 1; rv.dout = '0;
    chk_std(-1, rv);
    chk("f_empty_rst", 0, 64'(f_empty), 64'd1);
    chk("f_count_rst", 0, 64'(f_count), 64'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      s_we = vq[i].we; s_re = vq[i].re; s_clr = vq[i].clr; s_din = vq[i].din;
      @(posedge clk);
      #1;
      chk_std(i, vq[i]);
    end

    // Reset while count=3 with we&re active: reset wins and discards contents.
    @(negedge clk);
    rst = 1'b0; s_we = 1; s_re = 1; s_din = 34'h25;
    @(posedge clk);
    #1;
    chk_std(100, rv);
    @(negedge clk);
    rst = 1'b1; s_we = 0; s_re = 0; s_din = '0;
    @(posedge clk);
    #1;
    chk_std(101, rv);

    // FWFT: head word visible right after its write edge, re acknowledges.
    @(negedge clk);
    f_we = 1; f_din = 34'hAA;
    @(posedge clk);
    #1;
    chk("f_dout_first", 0, 64'(f_dout), 64'h0AA);
    chk("f_empty_first", 0, 64'(f_empty), 64'd0);
    @(negedge clk);
    f_din = 34'hBB;
    @(posedge clk);
    #1;
    chk("f_dout_hold", 0, 64'(f_dout), 64'h0AA);
    chk("f_count2", 0, 64'(f_count), 64'd2);
    @(negedge clk);
    f_we = 0; f_re = 1;
    @(posedge clk);
    #1;
    chk("f_dout_next", 0, 64'(f_dout), 64'h0BB);
    chk("f_count1", 0, 64'(f_count), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("f_empty_last", 0, 64'(f_empty), 64'd1);
    chk("f_count0", 0, 64'(f_count), 64'd0);
    chk("f_underflow0", 0, 64'(f_un), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("f_underflow1", 0, 64'(f_un), 64'd1);
    @(negedge clk);
    f_re = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/generic_fifo_sc_p.md
Name: generic_fifo_sc_p

Overview:
Parametrised single-clock FIFO and successor to the fixed 32-bit, 4-entry FIFO used on the WMI response path.
- Width, depth and almost-full/almost-empty thresholds are parameters.
- An exact occupancy count is output.
- Overflow/underflow protection with sticky error flags.
- Selectable first-word-fall-through (FWFT) read mode.
- Sits between adapter bus interfaces (WCI/WMI/WSI) and their consumers.

Parameters:
DW, 34, data width in bits.
AW, 2, address width; DEPTH = 2^AW entries; AW >= 2.
AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH; range 1..DEPTH.
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH; range 0..DEPTH-1.
FWFT, 0, 0 = standard read (data 1 cycle after re); 1 = head word presented on dout while !empty.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
clr  in  1  synchronous clear, active-high.
din  in  DW  write data.
we  in  1  write request.
re  in  1  read request.
dout  out  DW  read data.
full  out  1  registered, count == DEPTH.
empty  out  1  registered, count == 0.
almost_full  out  1  registered, count >= AF_THRESH.
almost_empty  out  1  registered, count <= AE_THRESH.
count  out  AW+1  registered occupancy, 0..DEPTH.
level  out  2  occupancy quartile.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=0 at a clock edge) has priority over clr. Both force the same state:
  - wp=rp=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0, dout=0 (standard mode).
- Reset mid-operation discards all contents. The RAM array itself is not cleared.
- Accept rules, evaluated on the registered flags of the current cycle:
  - wr_ok = we & !full.
  - rd_ok = re & !empty.
- we while full: write dropped, pointers unchanged, overflow set to 1.
- re while empty: nothing read, underflow set to 1. dout holds in standard mode.
- Sticky flags clear only on rst or clr.
- Simultaneous events:
  - wr_ok & rd_ok: both pointers advance, count unchanged, flags unchanged.
  - Full with we&re: read accepted, write rejected (overflow set), count becomes DEPTH-1.
  - Empty with we&re: write accepted, read rejected (underflow set), count becomes 1.
- Pointers are AW bits and wrap modulo DEPTH with no gap.
- count next value: +1 on wr_ok only, -1 on rd_ok only, else hold.
- All status flags are registered and computed from count_next, so they change in the same edge as count. There is no combinational status path.
- level: 2'b11 when count == DEPTH, else count[AW-1:AW-2].
- Standard mode (FWFT=0): on rd_ok, dout loads mem[rp] at that edge and is valid the cycle after re. Otherwise dout holds.
- Write-to-read latency:
  - Standard mode: a word written at edge N is readable with re in cycle N+1.
  - FWFT mode: the word appears on dout after edge N.
- FWFT mode (FWFT=1): dout = mem[rp] combinationally from the registered rp. re acts as acknowledge; rp advances on rd_ok. dout is don't-care while empty.
- Memory write: mem[wp] <= din on wr_ok.

Decomposition:
- Shared package fifo_pkg:
  - Function clog2.
  - Level encodings LVL_Q0..LVL_Q3.
  - Default constants FIFO_DW_DEF=34, FIFO_AW_DEF=2.
- Sub-module fifo_mem_sc:
  - Parameters DW, AW, SYNC_RD.
  - Single write port, one read port.
  - Registered read with enable when SYNC_RD=1, asynchronous read when SYNC_RD=0.
  - Instantiated with SYNC_RD = !FWFT.
- Control, pointer and flag logic live in the top level.

Test Plan:
1. AW=2, FWFT=0, reset then 4 writes 0x1..0x4 → count 1,2,3,4; almost_full at count=3; full=1 after the 4th edge; level=2'b11.
2. When full: we=1 with din=0x5 → count stays 4, overflow=1; four reads return 0x1..0x4 each one cycle after re, then empty=1, almost_empty=1 at count<=1.
3. When empty: re=1 → underflow=1, dout holds 0x4, count=0; then clr=1 → overflow=underflow=0, empty=1.
4. Wrap-around: 10 cycles of we&re after preloading 2 words → count stays 2, data order preserved across pointer wrap, no flag toggling.
5. FWFT=1: write 0xAA → dout=0xAA the cycle after the write edge; re → dout shows the next word or empty=1.
6. Reset mid-operation with count=3 and we&re active → next cycle count=0, empty=1, full=0, almost_full=0, flags cleared, dout=0 in standard mode.
